hier_access_ctrl: RTL and testbench

Sequencer for the two-level cache hierarchy. It accepts one CPU access at a time and checks L1. On an L1 miss it waits the L2 latency and checks L2; on an L2 miss it waits the memory latency. It then returns the data, drives the L1/L2 promotion strobes and keeps the hit/miss performance counters. It sits between the CPU trace source and the `l1_cache` / `l2_cache` / `main_memory` instances, taking over the sequencing and counting currently done inline at the top level.

---
 rtl/hier_access_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_hier_access_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hier_access_ctrl.sv
// hier_access_ctrl: one-access-at-a-time sequencer for the L1/L2/memory hierarchy.
// Checks L1, waits L2_LAT and checks L2 on a miss, waits MEM_LAT on a second miss,
// then holds the response and strobes the L1/L2 fills.
// Optional feature macro: HIER_PERF_CNT_EN builds the four hit/miss counters;
// without it the counter outputs are tied to zero.
module hier_access_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int L2_LAT  = 10,
    parameter int MEM_LAT = 100,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic [ADDR_W-1:0] lookup_addr,
    input  logic              l1_hit,
    input  logic [DATA_W-1:0] l1_data,
    output logic              l2_lookup,
    input  logic              l2_hit,
    input  logic [DATA_W-1:0] l2_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic              promote_l1,
    output logic [DATA_W-1:0] promote_l1_data,
    output logic              promote_l2,
    output logic [DATA_W-1:0] promote_l2_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [1:0]        resp_level,
    output logic [CNT_W-1:0]  l1_hit_cnt,
    output logic [CNT_W-1:0]  l1_miss_cnt,
    output logic [CNT_W-1:0]  l2_hit_cnt,
    output logic [CNT_W-1:0]  l2_miss_cnt
);

    localparam int MAX_LAT = (L2_LAT > MEM_LAT) ? L2_LAT : MEM_LAT;
    localparam int WAIT_W  = $clog2(MAX_LAT + 1);
    localparam logic [WAIT_W-1:0] L2_LOAD  = WAIT_W'(L2_LAT - 1);
    localparam logic [WAIT_W-1:0] MEM_LOAD = WAIT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        L1_CHK   = 3'd1,
        L2_WAIT  = 3'd2,
        MEM_WAIT = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic [1:0]          resp_level_q, resp_level_d;
    logic                l2_lookup_q, l2_lookup_d;
    logic                promote_l1_q, promote_l1_d;
    logic                promote_l2_q, promote_l2_d;
    logic [DATA_W-1:0]   promote_l1_data_q, promote_l1_data_d;
    logic [DATA_W-1:0]   promote_l2_data_q, promote_l2_data_d;

    // Next-state and registered-output logic; strobes default low so they last one cycle
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        wait_d            = wait_q;
        resp_data_d       = resp_data_q;
        resp_level_d      = resp_level_q;
        l2_lookup_d       = 1'b0;
        promote_l1_d      = 1'b0;
        promote_l2_d      = 1'b0;
        promote_l1_data_d = promote_l1_data_q;
        promote_l2_data_d = promote_l2_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = L1_CHK;
                end
            end
            L1_CHK: begin
                if (l1_hit) begin
                    resp_data_d  = l1_data;
                    resp_level_d = 2'd1;
                    state_d      = RESP;
                end else begin
                    l2_lookup_d = 1'b1;
                    wait_d      = L2_LOAD;
                    state_d     = L2_WAIT;
                end
            end
            L2_WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else if (l2_hit) begin
                    resp_data_d       = l2_data;
                    resp_level_d      = 2'd2;
                    promote_l1_d      = 1'b1;
                    promote_l1_data_d = l2_data;
                    state_d           = RESP;
                end else begin
                    wait_d  = MEM_LOAD;
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    resp_data_d       = mem_data;
                    resp_level_d      = 2'd3;
                    promote_l1_d      = 1'b1;
                    promote_l2_d      = 1'b1;
                    promote_l1_data_d = mem_data;
                    promote_l2_data_d = mem_data;
                    state_d           = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            wait_q            <= '0;
            resp_data_q       <= '0;
            resp_level_q      <= '0;
            l2_lookup_q       <= 1'b0;
            promote_l1_q      <= 1'b0;
            promote_l2_q      <= 1'b0;
            promote_l1_data_q <= '0;
            promote_l2_data_q <= '0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            wait_q            <= wait_d;
            resp_data_q       <= resp_data_d;
            resp_level_q      <= resp_level_d;
            l2_lookup_q       <= l2_lookup_d;
            promote_l1_q      <= promote_l1_d;
            promote_l2_q      <= promote_l2_d;
            promote_l1_data_q <= promote_l1_data_d;
            promote_l2_data_q <= promote_l2_data_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = (state_q == RESP);
    assign lookup_addr     = addr_q;
    assign l2_lookup       = l2_lookup_q;
    assign promote_l1      = promote_l1_q;
    assign promote_l2      = promote_l2_q;
    assign promote_l1_data = promote_l1_data_q;
    assign promote_l2_data = promote_l2_data_q;
    assign resp_data       = resp_data_q;
    assign resp_level      = resp_level_q;

`ifdef HIER_PERF_CNT_EN
    logic [CNT_W-1:0] l1_hit_cnt_q, l1_hit_cnt_d;
    logic [CNT_W-1:0] l1_miss_cnt_q, l1_miss_cnt_d;
    logic [CNT_W-1:0] l2_hit_cnt_q, l2_hit_cnt_d;
    logic [CNT_W-1:0] l2_miss_cnt_q, l2_miss_cnt_d;
    logic             l2_decide;

    // Counters bump on the same edge that makes the hit/miss decision
    always_comb begin
        l1_hit_cnt_d  = l1_hit_cnt_q;
        l1_miss_cnt_d = l1_miss_cnt_q;
        l2_hit_cnt_d  = l2_hit_cnt_q;
        l2_miss_cnt_d = l2_miss_cnt_q;
        l2_decide     = (state_q == L2_WAIT) && (wait_q == '0);
        if (state_q == L1_CHK) begin
            if (l1_hit) l1_hit_cnt_d  = l1_hit_cnt_q + 1'b1;
            else        l1_miss_cnt_d = l1_miss_cnt_q + 1'b1;
        end
        if (l2_decide) begin
            if (l2_hit) l2_hit_cnt_d  = l2_hit_cnt_q + 1'b1;
            else        l2_miss_cnt_d = l2_miss_cnt_q + 1'b1;
        end
    end

    // Counter registers, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1_hit_cnt_q  <= '0;
            l1_miss_cnt_q <= '0;
            l2_hit_cnt_q  <= '0;
            l2_miss_cnt_q <= '0;
        end else begin
            l1_hit_cnt_q  <= l1_hit_cnt_d;
            l1_miss_cnt_q <= l1_miss_cnt_d;
            l2_hit_cnt_q  <= l2_hit_cnt_d;
            l2_miss_cnt_q <= l2_miss_cnt_d;
        end
    end

    assign l1_hit_cnt  = l1_hit_cnt_q;
    assign l1_miss_cnt = l1_miss_cnt_q;
    assign l2_hit_cnt  = l2_hit_cnt_q;
    assign l2_miss_cnt = l2_miss_cnt_q;
`else
    assign l1_hit_cnt  = '0;
    assign l1_miss_cnt = '0;
    assign l2_hit_cnt  = '0;
    assign l2_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_hier_access_ctrl.sv
// Testbench for hier_access_ctrl: directed scenarios plus randomized accesses
// against a transaction-level reference model.
module tb_hier_access_ctrl;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 32;
    localparam int L2_LAT  = 10;
    localparam int MEM_LAT = 100;
    localparam int CNT_W   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic [ADDR_W-1:0] lookup_addr;
    logic              l1_hit;
    logic [DATA_W-1:0] l1_data;
    logic              l2_lookup;
    logic              l2_hit;
    logic [DATA_W-1:0] l2_data;
    logic [DATA_W-1:0] mem_data;
    logic              promote_l1;
    logic [DATA_W-1:0] promote_l1_data;
    logic              promote_l2;
    logic [DATA_W-1:0] promote_l2_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [1:0]        resp_level;
    logic [CNT_W-1:0]  l1_hit_cnt, l1_miss_cnt, l2_hit_cnt, l2_miss_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state: how many accesses resolved at each level since reset
    int m_l1_hit, m_l1_miss, m_l2_hit, m_l2_miss;

    hier_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .L2_LAT(L2_LAT),
        .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .lookup_addr(lookup_addr),
        .l1_hit(l1_hit), .l1_data(l1_data),
        .l2_lookup(l2_lookup), .l2_hit(l2_hit), .l2_data(l2_data),
        .mem_data(mem_data),
        .promote_l1(promote_l1), .promote_l1_data(promote_l1_data),
        .promote_l2(promote_l2), .promote_l2_data(promote_l2_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_level(resp_level),
        .l1_hit_cnt(l1_hit_cnt), .l1_miss_cnt(l1_miss_cnt),
        .l2_hit_cnt(l2_hit_cnt), .l2_miss_cnt(l2_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        int e1h, e1m, e2h, e2m;
`ifdef HIER_PERF_CNT_EN
        e1h = m_l1_hit; e1m = m_l1_miss; e2h = m_l2_hit; e2m = m_l2_miss;
`else
        e1h = 0; e1m = 0; e2h = 0; e2m = 0;
`endif
        check({tag, ".l1_hit_cnt"},  64'(l1_hit_cnt),  64'(CNT_W'(e1h)));
        check({tag, ".l1_miss_cnt"}, 64'(l1_miss_cnt), 64'(CNT_W'(e1m)));
        check({tag, ".l2_hit_cnt"},  64'(l2_hit_cnt),  64'(CNT_W'(e2h)));
        check({tag, ".l2_miss_cnt"}, 64'(l2_miss_cnt), 64'(CNT_W'(e2m)));
    endtask

    // One complete access: request, wait for response, hold it `hold` cycles, release.
    // Called and returning at a negative clock edge.
    task automatic do_access(input string tag, input logic [ADDR_W-1:0] a,
                             input bit h1, input bit h2,
                             input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                             input logic [DATA_W-1:0] dm,
                             input bit early_ready, input int hold);
        int exp_lat, n, l2l_cnt, l2l_at, p1_cnt, p1_at, p2_cnt, p2_at;
        bit got;
        logic [DATA_W-1:0] exp_data, p1d, p2d;
        logic [1:0] exp_level;

        n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".idle_before"}, 64'(req_ready), 64'd1);

        // Reference: where the data comes from and how long it takes
        if (h1) begin
            exp_lat = 1; exp_level = 2'd1; exp_data = d1;
            m_l1_hit++;
        end else if (h2) begin
            exp_lat = 1 + L2_LAT; exp_level = 2'd2; exp_data = d2;
            m_l1_miss++; m_l2_hit++;
        end else begin
            exp_lat = 1 + L2_LAT + MEM_LAT; exp_level = 2'd3; exp_data = dm;
            m_l1_miss++; m_l2_miss++;
        end

        req_valid = 1'b1; req_addr = a;
        l1_hit = h1; l2_hit = h2; l1_data = d1; l2_data = d2; mem_data = dm;
        resp_ready = early_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = ADDR_W'($urandom);
        check({tag, ".lookup_addr"}, 64'(lookup_addr), 64'(a));

        n = 0; got = 1'b0;
        l2l_cnt = 0; l2l_at = -1; p1_cnt = 0; p1_at = -1; p2_cnt = 0; p2_at = -1;
        p1d = '0; p2d = '0;
        while (!got && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (l2_lookup)  begin l2l_cnt++; l2l_at = n; end
            if (promote_l1) begin p1_cnt++; p1_at = n; p1d = promote_l1_data; end
            if (promote_l2) begin p2_cnt++; p2_at = n; p2d = promote_l2_data; end
            if (resp_valid) got = 1'b1;
        end
        check({tag, ".latency"},    64'(n), 64'(exp_lat));
        check({tag, ".resp_level"}, 64'(resp_level), 64'(exp_level));
        check({tag, ".resp_data"},  64'(resp_data), 64'(exp_data));
        check({tag, ".req_ready_busy"}, 64'(req_ready), 64'd0);
        check({tag, ".l2_lookup_cnt"}, 64'(l2l_cnt), h1 ? 64'd0 : 64'd1);
        if (!h1) check({tag, ".l2_lookup_at"}, 64'(l2l_at), 64'd1);
        check({tag, ".promote_l1_cnt"}, 64'(p1_cnt), h1 ? 64'd0 : 64'd1);
        check({tag, ".promote_l2_cnt"}, 64'(p2_cnt), (!h1 && !h2) ? 64'd1 : 64'd0);
        if (!h1) begin
            check({tag, ".promote_l1_at"},   64'(p1_at), 64'(exp_lat));
            check({tag, ".promote_l1_data"}, 64'(p1d), 64'(exp_data));
        end
        if (!h1 && !h2) begin
            check({tag, ".promote_l2_at"},   64'(p2_at), 64'(exp_lat));
            check({tag, ".promote_l2_data"}, 64'(p2d), 64'(exp_data));
        end
        check_counters(tag);

        if (!early_ready) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                req_valid = 1'($urandom);
                req_addr  = ADDR_W'($urandom);
                @(posedge clk);
                #1;
                check({tag, ".hold_valid"},   64'(resp_valid), 64'd1);
                check({tag, ".hold_data"},    64'(resp_data), 64'(exp_data));
                check({tag, ".hold_level"},   64'(resp_level), 64'(exp_level));
                check({tag, ".hold_ready"},   64'(req_ready), 64'd0);
                check({tag, ".hold_addr"},    64'(lookup_addr), 64'(a));
                check({tag, ".hold_prom"},    64'({promote_l1, promote_l2}), 64'd0);
            end
            @(negedge clk);
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, ".release_valid"}, 64'(resp_valid), 64'd0);
        check({tag, ".release_ready"}, 64'(req_ready), 64'd1);
        check({tag, ".release_prom"},  64'({promote_l1, promote_l2}), 64'd0);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        int pick, a_int;
        bit h1, h2;
        int p1_seen, rv_seen;

        m_l1_hit = 0; m_l1_miss = 0; m_l2_hit = 0; m_l2_miss = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        l1_hit = 1'b0; l2_hit = 1'b0; l1_data = '0; l2_data = '0; mem_data = '0;

        #1;
        check("rst.req_ready",  64'(req_ready), 64'd1);
        check("rst.resp_valid", 64'(resp_valid), 64'd0);
        check("rst.outputs", 64'({l2_lookup, promote_l1, promote_l2, resp_level}), 64'd0);
        check("rst.lookup_addr", 64'(lookup_addr), 64'd0);
        check("rst.resp_data",   64'(resp_data), 64'd0);
        check_counters("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: one access served from each level
        do_access("l1hit", 11'h012, 1'b1, 1'b0, 32'hDEADBEEF, 32'h1111_1111, 32'h2222_2222, 1'b0, 1);
        do_access("l2hit", 11'h100, 1'b0, 1'b1, 32'h3333_3333, 32'hCAFE0001, 32'h4444_4444, 1'b0, 1);
        do_access("mem",   11'h7FF, 1'b0, 1'b0, 32'h5555_5555, 32'h6666_6666, 32'h00000123, 1'b0, 1);
        // Response held for five cycles while requests are pulsed
        do_access("hold",  11'h2A5, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h0, 32'h0, 1'b0, 5);
        // resp_ready raised before the response exists: single RESP cycle
        do_access("early", 11'h0F0, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 0);

        // Randomized accesses
        for (int t = 0; t < 24; t++) begin
            pick = int'($urandom_range(0, 2));
            h1 = (pick == 0);
            h2 = (pick == 1);
            a_int = int'($urandom_range(0, (1 << ADDR_W) - 1));
            do_access("rand", ADDR_W'(a_int), h1, h2, $urandom, $urandom, $urandom,
                      1'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset 50 cycles into the memory wait
        req_valid = 1'b1; req_addr = 11'h155;
        l1_hit = 1'b0; l2_hit = 1'b0; mem_data = 32'hA5A5_A5A5; l2_data = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (1 + L2_LAT + 50) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        m_l1_hit = 0; m_l1_miss = 0; m_l2_hit = 0; m_l2_miss = 0;
        #1;
        check("midrst.req_ready",  64'(req_ready), 64'd1);
        check("midrst.resp_valid", 64'(resp_valid), 64'd0);
        check("midrst.prom",       64'({promote_l1, promote_l2}), 64'd0);
        check_counters("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        p1_seen = 0; rv_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (promote_l1 || promote_l2) p1_seen++;
            if (resp_valid || !req_ready) rv_seen++;
        end
        check("midrst.no_promote", 64'(p1_seen), 64'd0);
        check("midrst.stay_idle",  64'(rv_seen), 64'd0);
        check_counters("midrst_after");
        @(negedge clk);

        // Normal operation resumes after the abandoned access
        do_access("post", 11'h3C3, 1'b0, 1'b1, 32'h0, 32'hFEED_0042, 32'h0, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
